// File: rtl/pc_unit.sv
// Program-counter unit at the head of fetch: sequential advance, redirect,
// trap vector with stall-pending latch, and a circular return-address stack.
module pc_unit #(
  parameter int unsigned     WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = 32'h0000_0000,
  parameter logic [WIDTH-1:0] TRAP_VEC  = 32'h0000_0180,
  parameter int unsigned     STEP      = 4,
  parameter int unsigned     RAS_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         stall,
  input  logic                         trap,
  input  logic                         redirect,
  input  logic [WIDTH-1:0]             redirect_pc,
  input  logic                         call,
  input  logic                         ret,
  output logic [WIDTH-1:0]             pc,
  output logic [WIDTH-1:0]             pc_plus,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         trap_taken
);

  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] ras [RAS_DEPTH];
  logic [PW-1:0]    wr_ptr, wr_ptr_nxt;
  logic [CW-1:0]    cnt_nxt;
  logic [WIDTH-1:0] pc_nxt;
  logic             pending, pending_nxt;
  logic             taken_nxt;
  logic             push;

  assign pc_plus = pc + WIDTH'(STEP);

  always_comb begin
    pc_nxt      = pc;
    cnt_nxt     = ras_count;
    wr_ptr_nxt  = wr_ptr;
    pending_nxt = pending;
    taken_nxt   = 1'b0;
    push        = 1'b0;
    if (stall) begin
      pending_nxt = pending | trap;
    end else if (trap || pending) begin
      pc_nxt      = TRAP_VEC;
      cnt_nxt     = '0;
      pending_nxt = 1'b0;
      taken_nxt   = 1'b1;
    end else if (ret && ras_count != '0) begin
      pc_nxt     = ras[wr_ptr - 1'b1];
      wr_ptr_nxt = wr_ptr - 1'b1;
      cnt_nxt    = ras_count - 1'b1;
    end else if (ret) begin
      pc_nxt = redirect_pc;
    end else if (redirect) begin
      pc_nxt = redirect_pc;
      if (call) begin
        // On a full stack the write pointer wraps onto the oldest entry.
        push       = 1'b1;
        wr_ptr_nxt = wr_ptr + 1'b1;
        if (ras_count != CW'(RAS_DEPTH))
          cnt_nxt = ras_count + 1'b1;
      end
    end else begin
      pc_nxt = pc_plus;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= RESET_VEC;
      ras_count  <= '0;
      wr_ptr     <= '0;
      pending    <= 1'b0;
      trap_taken <= 1'b0;
    end else begin
      pc         <= pc_nxt;
      ras_count  <= cnt_nxt;
      wr_ptr     <= wr_ptr_nxt;
      pending    <= pending_nxt;
      trap_taken <= taken_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push)
      ras[wr_ptr] <= pc_plus;
  end

endmodule
